// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - word-pair input and sum-word output handshake bundle
interface wide_add_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - word-serial wide add/subtract, LSW first, carry chained between words
module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input logic                 clk,
  input logic                 rst,
  wide_add_sequencer_if.slave bus
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sub_q, carry_q;
  logic          acc, last_word, s, ci, cout, c31;
  logic [31:0]   b_eff, sum;

  logic          out_valid_q, out_last_q, out_cout_q, out_ovf_q;
  logic [31:0]   out_sum_q;

  // Single output register: accept only when it is empty or being drained.
  assign bus.in_ready  = ~rst & (~out_valid_q | bus.out_ready);
  assign acc           = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

  // First word takes mode and carry from the port; later words use the latched values.
  always_comb begin
    s         = (state_q == IDLE) ? bus.in_sub : sub_q;
    ci        = (state_q == IDLE) ? (bus.in_cin ^ bus.in_sub) : carry_q;
    b_eff     = bus.in_b ^ {32{s}};
    {cout, sum} = {1'b0, bus.in_a} + {1'b0, b_eff} + {32'd0, ci};
    c31       = sum[31] ^ bus.in_a[31] ^ b_eff[31];
    last_word = (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (acc) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          idx_d   = IW'(1);
        end
        RUN: begin
          if (last_word) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (acc) begin
      if (state_q == IDLE) sub_q <= bus.in_sub;
      carry_q     <= last_word ? 1'b0 : cout;
      out_valid_q <= 1'b1;
      out_sum_q   <= sum;
      out_last_q  <= last_word;
      out_cout_q  <= cout;
      out_ovf_q   <= c31 ^ cout;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - randomized bench against a full-width arithmetic model
module tb_wide_add_sequencer;
  localparam int NW = 4;
  localparam int W  = 32 * NW;

  typedef struct {
    logic [31:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   cmp = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall_until = 0;
  int   stall_seen = 0;
  bit   rdy_rand = 1'b0;

  wide_add_sequencer_if bus();

  wide_add_sequencer #(.NWORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    cmp++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Whole-operand arithmetic; signed overflow from a sign-extended sum.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] res, output logic cout, output logic ovf);
    logic [W-1:0] beff;
    logic         ci;
    logic [W:0]   u, sx;
    beff = sub ? ~b : b;
    ci   = cin ^ sub;
    u    = {1'b0, a} + {1'b0, beff} + (W+1)'(ci);
    sx   = {a[W-1], a} + {beff[W-1], beff} + (W+1)'(ci);
    res  = u[W-1:0];
    cout = u[W];
    ovf  = sx[W] ^ sx[W-1];
  endfunction

  task automatic pin_model(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub,
                           input logic [W-1:0] r_exp, input logic c_exp, input logic o_exp);
    logic [W-1:0] r;
    logic c, o;
    model(a, b, cin, sub, r, c, o);
    check({name, "_sum"}, r, r_exp);
    check({name, "_cout"}, W'(c), W'(c_exp));
    check({name, "_ovf"}, W'(o), W'(o_exp));
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W-1:0] r;
    logic c, o;
    exp_t e;
    model(a, b, cin, sub, r, c, o);
    for (int w = 0; w < NW; w++) begin
      e.sum  = r[32*w +: 32];
      e.last = (w == NW - 1);
      e.cout = c;
      e.ovf  = o;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 1000) begin
        cmp++;
        bad++;
        $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    push_exp(a, b, cin, sub);
    for (int w = 0; w < NW; w++)
      send_word(a[32*w +: 32], b[32*w +: 32],
                (w == 0) ? cin : 1'($urandom), (w == 0) ? sub : 1'($urandom));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain", W'(exp_q.size()), '0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc < stall_until) bus.out_ready = 1'b0;
    else if (rdy_rand)     bus.out_ready = ($urandom_range(0, 3) != 0);
    else                   bus.out_ready = 1'b1;
  end

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        pend;
    logic        prev_stall;
    logic [31:0] prev_sum;
    logic        prev_last;
    if (rst) begin
      pend       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", W'(bus.in_ready), W'(!bus.out_valid || bus.out_ready));
      if (pend) check("latency", W'(bus.out_valid), W'(1));
      if (prev_stall) begin
        check("hold_sum", W'(bus.out_sum), W'(prev_sum));
        check("hold_last", W'(bus.out_last), W'(prev_last));
      end
      if (bus.out_valid && !bus.out_ready && !bus.in_ready) stall_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL extra_word: got %0h expected no word", bus.out_sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", W'(bus.out_sum), W'(e.sum));
          check("last", W'(bus.out_last), W'(e.last));
          if (e.last) begin
            check("cout", W'(bus.out_cout), W'(e.cout));
            check("ovf", W'(bus.out_ovf), W'(e.ovf));
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.out_sum;
      prev_last  = bus.out_last;
      pend       = bus.in_valid && bus.in_ready;
    end
  end

  initial begin
    logic [W-1:0] a, b;
    int s0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_cin   = 1'b0;
    bus.in_sub   = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(bus.in_ready), '0);
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_out_sum", W'(bus.out_sum), '0);
    check("rst_out_last", W'(bus.out_last), '0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #2;

    pin_model("t1", 128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
              128'h00000002_00000000_00000000_00000000, 1'b0, 1'b0);
    send_op(128'h00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0);
    pin_model("t2", {W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, {W{1'b1}}, 1'b1, 1'b0);
    send_op({W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0);
    pin_model("t3a", 128'd0, 128'd1, 1'b0, 1'b1, {W{1'b1}}, 1'b0, 1'b0);
    send_op(128'd0, 128'd1, 1'b0, 1'b1);
    pin_model("t3b", 128'd5, 128'd3, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0);
    send_op(128'd5, 128'd3, 1'b0, 1'b1);
    pin_model("t4", 128'h7FFFFFFF_00000000_00000000_00000000, 128'h00000001_00000000_00000000_00000000,
              1'b0, 1'b0, 128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);
    send_op(128'h7FFFFFFF_00000000_00000000_00000000, 128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
    drain();

    // Three-cycle downstream stall while word 2 sits in the output register.
    a = {$urandom, $urandom, 32'hFFFFFFFF, 32'hFFFFFFFF};
    b = {$urandom, $urandom, $urandom, 32'h00000001};
    s0 = stall_seen;
    push_exp(a, b, 1'b0, 1'b0);
    send_word(a[31:0], b[31:0], 1'b0, 1'b0);
    send_word(a[63:32], b[63:32], 1'b1, 1'b1);
    stall_until = cyc + 4;
    send_word(a[95:64], b[95:64], 1'b0, 1'b1);
    send_word(a[127:96], b[127:96], 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    check("stall_cycles", W'(stall_seen - s0), W'(3));

    // Reset mid-operation after a subtract word that leaves a carry behind.
    push_exp(128'd0, 128'd0, 1'b0, 1'b1);
    send_word(32'd0, 32'd0, 1'b0, 1'b1);
    send_word(32'd0, 32'd0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", W'(bus.in_ready), '0);
    @(negedge clk);
    check("rst_mid_out_valid", W'(bus.out_valid), '0);
    check("rst_mid_out_sum", W'(bus.out_sum), '0);
    check("rst_mid_out_last", W'(bus.out_last), '0);
    @(posedge clk);
    #2;
    exp_q.delete();
    rst = 1'b0;
    pin_model("t6", 128'd1, 128'd1, 1'b0, 1'b0, 128'd2, 1'b0, 1'b0);
    send_op(128'd1, 128'd1, 1'b0, 1'b0);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 7))
        0: a = {W{1'b1}};
        1: b = {W{1'b1}};
        2: b = '0;
        3: a = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      send_op(a, b, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
